term_stream_writer: RTL and testbench
=====================================

# term_stream_writer

Host-side driver for the character terminal peripheral: accepts a byte stream (ASCII/CP437 plus a small control set) over a valid/ready handshake and converts it into the terminal's `data`/`dstrobe`/`dtype` write protocol. It sits between a byte source (UART receiver, CPU port) and the terminal on the host clock domain. It keeps a shadow cursor that mirrors the terminal's auto-increment rule exactly, so CR/LF/BS/TAB/positioning need no read-back.

## Interface
- `COLS`, 80, character columns; terminal column wrap point.
- `ROWS`, 40, character rows; terminal row wrap point.
- `CLK_I`  in  1  host bus clock; the terminal latches writes on this edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready` at a rising edge.
- `data`  out  8  terminal data: char code, column or row.
- `dstrobe`  out  1  one-cycle terminal write strobe.
- `dtype`  out  2  0 = char, 1 = column, 2 = row.
- `busy`  out  1  high while a multi-strobe command (clear) is in progress.
- `row`  out  6  shadow cursor row.
- `col`  out  7  shadow cursor column.

## Operation
- Decoding of each accepted byte in IDLE:
  - 0x20–0x7E and 0x80–0xFF: char write (`dtype` 0). Shadow col += 1. At col == COLS-1, col wraps to 0 and row += 1, wrapping ROWS-1 -> 0.
  - 0x0D (CR): col = 0; column write with data 0.
  - 0x0A (LF): row = (row+1) mod ROWS; row write.
  - 0x08 (BS): if col > 0, col -= 1 and column write; at col 0, no strobe.
  - 0x09 (TAB): col = min((col|7)+1, COLS-1); column write.
  - 0x0C (FF): clear sequence, described below.
  - 0x1B (ESC): go to ESC state.
  - All other bytes (0x00–0x1F not listed above, and 0x7F): discarded with no strobe.
- States: IDLE, ESC, ESC_ROW, ESC_COL, POS_ROW, CLEAR.
  - ESC: next byte 'Y' (0x59) -> ESC_ROW; any other byte is dropped -> IDLE.
  - ESC_ROW: byte minus 0x20 is clamped to ROWS-1 and held -> ESC_COL. A byte below 0x20 clamps to 0.
  - ESC_COL: byte minus 0x20 is clamped to COLS-1. Column write issued -> POS_ROW. POS_ROW issues the row write -> IDLE. Shadow cursor updates to the new row/col.
- CLEAR sequence:
  - Strobes in order: column 0, row 0, then COLS*ROWS char writes of 0x20, then column 0, row 0.
  - 12-bit fill counter.
  - Shadow cursor ends at (0,0).
- `in_ready` = 1 only in IDLE, ESC, ESC_ROW and ESC_COL, and only when no strobe is pending for the next cycle.

## Timing
- Outputs are registered. A byte accepted at edge N produces `dstrobe` high for exactly the cycle after edge N, with `data`/`dtype` stable in that same cycle.
- `dstrobe` is never high in two consecutive cycles, except inside CLEAR and the ESC_COL→POS_ROW pair, where strobes are back-to-back, one per cycle.
- Single-strobe commands: `in_ready` drops for 1 cycle. Back-to-back printable bytes therefore sustain 1 char per 2 cycles.
- CLEAR: COLS*ROWS+4 strobes (3204 at default) on consecutive cycles. `busy` is high from the cycle after FF acceptance through the last strobe. `in_ready` is low throughout.
- `row`/`col` update on the same edge that raises the corresponding `dstrobe`.
- Reset values: `dstrobe` 0, `dtype` 0, `data` 0, `busy` 0, `row` 0, `col` 0, state IDLE, `in_ready` 1 after reset deasserts.
- Reset mid-CLEAR or mid-ESC aborts immediately and emits no further strobes. The terminal's cursor is not reset by this block, so upstream sends FF after reset to resynchronise.
- `in_valid` without acceptance: the byte must be held by the source; the block never samples `in_data` while `in_ready` is 0.

## Structure
- Shared package `term_pkg`:
  - Constants TERM_COLS/TERM_ROWS.
  - `dtype` encodings DT_CHAR/DT_COL/DT_ROW.
  - Control codes CH_BS/CH_TAB/CH_LF/CH_FF/CH_CR/CH_ESC.
  - State enum.
- Single module; no sub-module. The cursor-advance function lives in the package and is shared with any terminal model in the bench.

## Test plan
- Reset, then send "AB" -> strobes dtype 0 data 0x41 then 0x42; `col` 1 then 2; `row` 0.
- Set col 78 via ESC Y 0x20 0x6E, then send 'x','y' -> strobes: col 78, row 0, 'x' (`col` 79), 'y' (`col` 0, `row` 1).
- At row 39, col 5: CR then LF -> column write data 0, then row write data 0; shadow cursor (0,0).
- FF -> 3204 consecutive strobes: first two col 0 / row 0, 3200 × 0x20, last two col 0 / row 0; `busy` high for exactly 3204 cycles; `in_ready` low throughout.
- ESC Y 0x7F 0x7F -> clamped column write 79 and row write 39 on consecutive cycles; BS at col 0 -> no strobe; 0x07 -> no strobe.
- Assert `RST_N` low at fill count 1000 of a clear -> `dstrobe` 0 immediately, `busy` 0, `row`/`col` 0; FF after release runs a full 3204-strobe clear.

Source files
------------

// File: rtl/term_pkg.sv
// ---------------------------------------------------------------------------
// term_pkg
// Definitions shared by the terminal stream writer and any terminal model:
//   - default geometry (TERM_COLS x TERM_ROWS)
//   - dtype encodings for the terminal write protocol
//   - recognised control codes
//   - writer FSM states and clear-sequence phases
//   - cursor type and the terminal's auto-increment rule
// ---------------------------------------------------------------------------
package term_pkg;

  localparam int TERM_COLS = 80;
  localparam int TERM_ROWS = 40;

  localparam logic [1:0] DT_CHAR = 2'd0;
  localparam logic [1:0] DT_COL  = 2'd1;
  localparam logic [1:0] DT_ROW  = 2'd2;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ESC_Y = 8'h59;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ESC,
    ST_ESC_ROW,
    ST_ESC_COL,
    ST_POS_ROW,
    ST_CLEAR
  } termState_e;

  // Order of strobes after the initial column-0 write of a clear.
  typedef enum logic [1:0] {
    CLR_ROW0,
    CLR_FILL,
    CLR_COL_END,
    CLR_ROW_END
  } clrPhase_e;

  typedef struct packed {
    logic [5:0] row;
    logic [6:0] col;
  } cursor_t;

  // Terminal auto-increment after a character write: the column wraps once
  // it has reached the last column, carrying into the row, which also wraps.
  function automatic cursor_t advanceCursor(input cursor_t cur,
                                            input logic [6:0] lastCol,
                                            input logic [5:0] lastRow);
    cursor_t nxt;
    nxt = cur;
    if (cur.col == lastCol) begin
      nxt.col = '0;
      nxt.row = (cur.row == lastRow) ? '0 : cur.row + 6'd1;
    end else begin
      nxt.col = cur.col + 7'd1;
    end
    return nxt;
  endfunction

  // Position byte of an ESC Y sequence: offset by 0x20, bytes below the
  // offset land on 0, anything past the last position is pinned to it.
  function automatic logic [7:0] clampOffset(input logic [7:0] b,
                                             input logic [7:0] maxPos);
    logic [7:0] off;
    off = b - CH_SPACE;
    if (b < CH_SPACE) begin
      return 8'd0;
    end else if (off > maxPos) begin
      return maxPos;
    end
    return off;
  endfunction

endpackage

// File: rtl/term_stream_writer.sv
// ---------------------------------------------------------------------------
// term_stream_writer
// Converts a valid/ready byte stream into the character terminal's
// data/dstrobe/dtype write protocol, tracking a shadow cursor so that cursor
// control bytes can be turned into absolute column/row writes.
//
// Ports:
//   CLK_I     in   host clock (terminal samples writes on the same edge)
//   RST_N     in   asynchronous active-low reset
//   in_data   in   stream byte
//   in_valid  in   in_data valid
//   in_ready  out  byte accepted when in_valid && in_ready at a rising edge
//   data      out  terminal data: character code, column or row
//   dstrobe   out  one-cycle terminal write strobe
//   dtype     out  0 char, 1 column, 2 row
//   busy      out  clear sequence in progress
//   row       out  shadow cursor row
//   col       out  shadow cursor column
// ---------------------------------------------------------------------------
module term_stream_writer
  import term_pkg::*;
#(
  parameter int COLS = TERM_COLS,
  parameter int ROWS = TERM_ROWS
) (
  input  logic       CLK_I,
  input  logic       RST_N,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data,
  output logic       dstrobe,
  output logic [1:0] dtype,
  output logic       busy,
  output logic [5:0] row,
  output logic [6:0] col
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [7:0]  MAX_COL8  = 8'(COLS - 1);
  localparam logic [7:0]  MAX_ROW8  = 8'(ROWS - 1);
  localparam logic [11:0] FILL_LAST = 12'(COLS * ROWS - 1);

  termState_e  state_q;
  clrPhase_e   clrPhase_q;
  logic [11:0] fill_q;
  logic [5:0]  escRow_q;
  logic [7:0]  data_q;
  logic [1:0]  dtype_q;
  logic        dstrobe_q;
  logic        busy_q;
  logic [5:0]  row_q;
  logic [6:0]  col_q;

  logic        accept;
  logic        isPrintable;
  cursor_t     advCursor_d;
  logic [7:0]  tabBase;
  logic [6:0]  tabCol_d;
  logic [5:0]  escRow_d;
  logic [6:0]  escCol_d;

  // Bytes are only taken in the decoding states, and never while a strobe
  // is on the bus, so every single-strobe command costs one idle cycle.
  assign in_ready = !dstrobe_q &&
                    ((state_q == ST_IDLE)    || (state_q == ST_ESC) ||
                     (state_q == ST_ESC_ROW) || (state_q == ST_ESC_COL));

  assign data    = data_q;
  assign dstrobe = dstrobe_q;
  assign dtype   = dtype_q;
  assign busy    = busy_q;
  assign row     = row_q;
  assign col     = col_q;

  // Candidate next cursor values for the different commands.
  always_comb begin
    accept      = in_valid && in_ready;
    isPrintable = (in_data >= CH_SPACE) && (in_data != CH_DEL);
    advCursor_d = advanceCursor(cursor_t'{row: row_q, col: col_q}, LAST_COL, LAST_ROW);
    tabBase     = ({1'b0, col_q} | 8'h07) + 8'd1;
    tabCol_d    = (tabBase > MAX_COL8) ? LAST_COL : 7'(tabBase);
    escRow_d    = 6'(clampOffset(in_data, MAX_ROW8));
    escCol_d    = 7'(clampOffset(in_data, MAX_COL8));
  end

  // Writer FSM. Every terminal write is registered: the strobe, its data and
  // type, and the shadow cursor all change on the same edge.
  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      clrPhase_q <= CLR_ROW0;
      fill_q     <= '0;
      escRow_q   <= '0;
      data_q     <= '0;
      dtype_q    <= DT_CHAR;
      dstrobe_q  <= 1'b0;
      busy_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      dstrobe_q <= 1'b0;
      busy_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (isPrintable) begin
              dstrobe_q <= 1'b1;
              dtype_q   <= DT_CHAR;
              data_q    <= in_data;
              row_q     <= advCursor_d.row;
              col_q     <= advCursor_d.col;
            end else begin
              case (in_data)
                CH_CR: begin
                  dstrobe_q <= 1'b1;
                  dtype_q   <= DT_COL;
                  data_q    <= 8'd0;
                  col_q     <= '0;
                end
                CH_LF: begin
                  dstrobe_q <= 1'b1;
                  dtype_q   <= DT_ROW;
                  data_q    <= {2'b00, advCursor_d.row == row_q ? ((row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1) : advCursor_d.row};
                  row_q     <= (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
                end
                CH_BS: begin
                  if (col_q != '0) begin
                    dstrobe_q <= 1'b1;
                    dtype_q   <= DT_COL;
                    data_q    <= {1'b0, col_q - 7'd1};
                    col_q     <= col_q - 7'd1;
                  end
                end
                CH_TAB: begin
                  dstrobe_q <= 1'b1;
                  dtype_q   <= DT_COL;
                  data_q    <= {1'b0, tabCol_d};
                  col_q     <= tabCol_d;
                end
                CH_FF: begin
                  // First strobe of the clear goes out with the acceptance.
                  dstrobe_q  <= 1'b1;
                  busy_q     <= 1'b1;
                  dtype_q    <= DT_COL;
                  data_q     <= 8'd0;
                  col_q      <= '0;
                  clrPhase_q <= CLR_ROW0;
                  fill_q     <= '0;
                  state_q    <= ST_CLEAR;
                end
                CH_ESC: begin
                  state_q <= ST_ESC;
                end
                default: begin
                end
              endcase
            end
          end
        end

        ST_ESC: begin
          if (accept) begin
            state_q <= (in_data == CH_ESC_Y) ? ST_ESC_ROW : ST_IDLE;
          end
        end

        ST_ESC_ROW: begin
          if (accept) begin
            escRow_q <= escRow_d;
            state_q  <= ST_ESC_COL;
          end
        end

        ST_ESC_COL: begin
          if (accept) begin
            dstrobe_q <= 1'b1;
            dtype_q   <= DT_COL;
            data_q    <= {1'b0, escCol_d};
            col_q     <= escCol_d;
            state_q   <= ST_POS_ROW;
          end
        end

        ST_POS_ROW: begin
          dstrobe_q <= 1'b1;
          dtype_q   <= DT_ROW;
          data_q    <= {2'b00, escRow_q};
          row_q     <= escRow_q;
          state_q   <= ST_IDLE;
        end

        ST_CLEAR: begin
          // One strobe per cycle; busy stays up through the final row write.
          dstrobe_q <= 1'b1;
          busy_q    <= 1'b1;
          case (clrPhase_q)
            CLR_ROW0: begin
              dtype_q    <= DT_ROW;
              data_q     <= 8'd0;
              row_q      <= '0;
              clrPhase_q <= CLR_FILL;
            end
            CLR_FILL: begin
              // The shadow cursor follows the auto-increment; a full screen
              // of writes brings it back to the origin.
              dtype_q <= DT_CHAR;
              data_q  <= CH_SPACE;
              row_q   <= advCursor_d.row;
              col_q   <= advCursor_d.col;
              fill_q  <= fill_q + 12'd1;
              if (fill_q == FILL_LAST) begin
                clrPhase_q <= CLR_COL_END;
              end
            end
            CLR_COL_END: begin
              dtype_q    <= DT_COL;
              data_q     <= 8'd0;
              col_q      <= '0;
              clrPhase_q <= CLR_ROW_END;
            end
            default: begin
              dtype_q    <= DT_ROW;
              data_q     <= 8'd0;
              row_q      <= '0;
              clrPhase_q <= CLR_ROW0;
              state_q    <= ST_IDLE;
            end
          endcase
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_term_stream_writer.sv
// Self-checking bench for term_stream_writer: a reference model of the
// terminal protocol pushes expected strobes into a queue as bytes are sent,
// and a monitor pops and compares them as the writer emits strobes.
module tb_term_stream_writer;

  logic       CLK_I;
  logic       RST_N;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       dstrobe;
  logic [1:0] dtype;
  logic       busy;
  logic [5:0] row;
  logic [6:0] col;

  int vecCount  = 0;
  int missCount = 0;

  // Expected strobe: {dtype, data, row, col} as seen in the strobe cycle.
  logic [22:0] expQ[$];

  int mState  = 0;
  int mRow    = 0;
  int mCol    = 0;
  int mEscRow = 0;

  int busyCycles   = 0;
  int busyStrobes  = 0;
  int busyReady    = 0;
  int strobeCount  = 0;

  term_stream_writer dut (
    .CLK_I    (CLK_I),
    .RST_N    (RST_N),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data     (data),
    .dstrobe  (dstrobe),
    .dtype    (dtype),
    .busy     (busy),
    .row      (row),
    .col      (col)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // Single point of comparison: counts and reports each check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushExp(input int dt, input int d);
    logic [1:0] dt2;
    logic [7:0] d8;
    logic [5:0] r6;
    logic [6:0] c7;
    dt2 = dt[1:0];
    d8  = d[7:0];
    r6  = mRow[5:0];
    c7  = mCol[6:0];
    expQ.push_back({dt2, d8, r6, c7});
  endtask

  task automatic modelAdvance();
    if (mCol == 79) begin
      mCol = 0;
      mRow = (mRow + 1) % 40;
    end else begin
      mCol = mCol + 1;
    end
  endtask

  function automatic int clampPos(input int b, input int maxPos);
    if (b < 32) return 0;
    if (b - 32 > maxPos) return maxPos;
    return b - 32;
  endfunction

  // Reference behaviour of the terminal write stream for one accepted byte.
  task automatic modelByte(input int b);
    case (mState)
      0: begin
        if (b >= 32 && b != 127) begin
          modelAdvance();
          pushExp(0, b);
        end else if (b == 13) begin
          mCol = 0;
          pushExp(1, 0);
        end else if (b == 10) begin
          mRow = (mRow + 1) % 40;
          pushExp(2, mRow);
        end else if (b == 8) begin
          if (mCol > 0) begin
            mCol = mCol - 1;
            pushExp(1, mCol);
          end
        end else if (b == 9) begin
          mCol = ((mCol | 7) + 1 > 79) ? 79 : (mCol | 7) + 1;
          pushExp(1, mCol);
        end else if (b == 12) begin
          mCol = 0;
          pushExp(1, 0);
          mRow = 0;
          pushExp(2, 0);
          for (int i = 0; i < 3200; i++) begin
            modelAdvance();
            pushExp(0, 32);
          end
          mCol = 0;
          pushExp(1, 0);
          mRow = 0;
          pushExp(2, 0);
        end else if (b == 27) begin
          mState = 1;
        end
      end
      1: mState = (b == 89) ? 2 : 0;
      2: begin
        mEscRow = clampPos(b, 39);
        mState  = 3;
      end
      default: begin
        mCol = clampPos(b, 79);
        pushExp(1, mCol);
        mRow = mEscRow;
        pushExp(2, mRow);
        mState = 0;
      end
    endcase
  endtask

  // Offer one byte, hold it until accepted, then withdraw it.
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    modelByte(int'(b));
    @(negedge CLK_I);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 5000) begin
      @(negedge CLK_I);
      guard++;
    end
    if (guard >= 5000) checkOutput("readyTimeout", in_ready, 1'b1);
    @(posedge CLK_I);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || dstrobe) && guard < 6000) begin
      @(negedge CLK_I);
      guard++;
    end
    if (guard >= 6000) checkOutput("drainTimeout", expQ.size(), 0);
    repeat (2) @(negedge CLK_I);
  endtask

  task automatic clearStats();
    busyCycles  = 0;
    busyStrobes = 0;
    busyReady   = 0;
    strobeCount = 0;
  endtask

  // Strobe monitor: compares each emitted write against the scoreboard.
  always @(negedge CLK_I) begin
    if (RST_N) begin
      if (busy) begin
        busyCycles++;
        if (dstrobe) busyStrobes++;
        if (in_ready) busyReady++;
      end
      if (dstrobe) begin
        strobeCount++;
        if (expQ.size() == 0) begin
          checkOutput("spuriousStrobe", dstrobe, 1'b0);
        end else begin
          checkOutput("strobe", {dtype, data, row, col}, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkClear(input string tag);
    checkOutput({tag, "BusyCycles"}, busyCycles, 3204);
    checkOutput({tag, "BusyStrobes"}, busyStrobes, 3204);
    checkOutput({tag, "ReadyInBusy"}, busyReady, 0);
    checkOutput({tag, "Row"}, row, 0);
    checkOutput({tag, "Col"}, col, 0);
  endtask

  initial begin
    RST_N    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK_I);
    checkOutput("rstStrobe", dstrobe, 1'b0);
    checkOutput("rstDtype", dtype, 2'd0);
    checkOutput("rstData", data, 8'd0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstRow", row, 6'd0);
    checkOutput("rstCol", col, 7'd0);
    RST_N = 1'b1;
    @(negedge CLK_I);
    checkOutput("rstReady", in_ready, 1'b1);

    // "AB" from the origin
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    waitDrain();
    checkOutput("abCol", col, 7'd2);
    checkOutput("abRow", row, 6'd0);

    // Position to col 78, then two characters across the wrap
    applyStimulus(8'h1B);
    applyStimulus(8'h59);
    applyStimulus(8'h20);
    applyStimulus(8'h6E);
    applyStimulus(8'h78);
    applyStimulus(8'h79);
    waitDrain();
    checkOutput("wrapCol", col, 7'd0);
    checkOutput("wrapRow", row, 6'd1);

    // Row 39 col 5, then CR and LF wrapping the row
    applyStimulus(8'h1B);
    applyStimulus(8'h59);
    applyStimulus(8'h47);
    applyStimulus(8'h25);
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    waitDrain();
    checkOutput("crlfRow", row, 6'd0);
    checkOutput("crlfCol", col, 7'd0);

    // Full clear
    clearStats();
    applyStimulus(8'h0C);
    waitDrain();
    checkClear("ff1");

    // Clamped positioning: column and row writes on consecutive cycles
    applyStimulus(8'h1B);
    applyStimulus(8'h59);
    applyStimulus(8'h7F);
    applyStimulus(8'h7F);
    @(negedge CLK_I);
    checkOutput("escColStrobe", {dstrobe, dtype, data}, {1'b1, 2'd1, 8'd79});
    @(negedge CLK_I);
    checkOutput("escRowStrobe", {dstrobe, dtype, data}, {1'b1, 2'd2, 8'd39});
    waitDrain();

    // BS at col 0 and BEL produce nothing and keep the input open
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    @(negedge CLK_I);
    checkOutput("bsNoStrobe", dstrobe, 1'b0);
    checkOutput("bsReady", in_ready, 1'b1);
    applyStimulus(8'h07);
    @(negedge CLK_I);
    checkOutput("belNoStrobe", dstrobe, 1'b0);
    checkOutput("belCol", col, 7'd0);

    // TAB, clamped TAB, BS, DEL discard, high characters, ESC with non-Y
    applyStimulus(8'h09);
    applyStimulus(8'h1B);
    applyStimulus(8'h59);
    applyStimulus(8'h20);
    applyStimulus(8'h6B);
    applyStimulus(8'h09);
    applyStimulus(8'h08);
    applyStimulus(8'h7F);
    applyStimulus(8'h80);
    applyStimulus(8'hFF);
    applyStimulus(8'h1B);
    applyStimulus(8'h41);
    applyStimulus(8'h41);
    waitDrain();
    checkOutput("mixRow", row, 6'd1);
    checkOutput("mixCol", col, 7'd1);

    // Reset in the middle of a clear
    clearStats();
    applyStimulus(8'h0C);
    begin
      int guard;
      guard = 0;
      while (strobeCount < 1002 && guard < 3000) begin
        @(negedge CLK_I);
        guard++;
      end
      if (guard >= 3000) checkOutput("midClearTimeout", strobeCount, 1002);
    end
    RST_N = 1'b0;
    expQ.delete();
    mState = 0;
    mRow   = 0;
    mCol   = 0;
    #1;
    checkOutput("abortStrobe", dstrobe, 1'b0);
    checkOutput("abortBusy", busy, 1'b0);
    checkOutput("abortRow", row, 6'd0);
    checkOutput("abortCol", col, 7'd0);
    repeat (3) begin
      @(negedge CLK_I);
      checkOutput("heldStrobe", dstrobe, 1'b0);
    end
    RST_N = 1'b1;
    @(negedge CLK_I);
    checkOutput("abortReady", in_ready, 1'b1);
    clearStats();
    applyStimulus(8'h0C);
    waitDrain();
    checkClear("ff2");
    applyStimulus(8'h5A);
    waitDrain();
    checkOutput("postCol", col, 7'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
